// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    typedef logic [1:0] tuse_t;

    localparam tuse_t TUSE_NONE    = 2'd3;
    localparam int    MULT_CYC_DEF = 5;
    localparam int    DIV_CYC_DEF  = 10;
    localparam int    MD_CNT_W     = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [4:0]  rsD;
    logic [4:0]  rtD;
    tuse_t       tuse_rsD;
    tuse_t       tuse_rtD;
    logic [4:0]  a3E;
    logic [4:0]  a3M;
    tuse_t       tnewE;
    tuse_t       tnewM;
    logic        md_useD;
    logic        md_startE;
    logic        md_divE;
    logic        excM;

    logic        stall_pc;
    logic        en_fd;
    logic        clr_fd;
    logic        clr_de;
    logic        clr_em;
    logic        clr_mw;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output rsD, rtD, tuse_rsD, tuse_rtD, a3E, a3M, tnewE, tnewM,
               md_useD, md_startE, md_divE, excM,
        input  stall_pc, en_fd, clr_fd, clr_de, clr_em, clr_mw, md_busy, stall_cycles
    );

    modport slave (
        input  rsD, rtD, tuse_rsD, tuse_rtD, a3E, a3M, tnewE, tnewM,
               md_useD, md_startE, md_divE, excM,
        output stall_pc, en_fd, clr_fd, clr_de, clr_em, clr_mw, md_busy, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// rtl/pipe_hazard_ctrl_md_busy_cnt.sv - load/decrement busy counter for the HI/LO unit
module md_busy_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                div_i,
    output logic [MD_CNT_W-1:0] cnt_o
);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    // A new issue always reloads, even mid-operation; otherwise count down to idle.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = div_i ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MD_CNT_W'(1);
        end
    end

    // Counter register; reset aborts any operation in flight, exceptions do not.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush control for register and HI/LO hazards
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    logic [MD_CNT_W-1:0] md_cnt;
    logic                md_busy;
    logic                haz_rs;
    logic                haz_rt;
    logic                stall;
    logic [31:0]         stall_cycles_q;
    logic [31:0]         stall_cycles_d;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .start_i (hz.md_startE),
        .div_i   (hz.md_divE),
        .cnt_o   (md_cnt)
    );

    // Hazard detection: an operand unused (tuse=3) can never lose to a 2-bit tnew.
    always_comb begin
        haz_rs  = (hz.rsD != 5'd0) &&
                  (((hz.rsD == hz.a3E) && (hz.tnewE > hz.tuse_rsD)) ||
                   ((hz.rsD == hz.a3M) && (hz.tnewM > hz.tuse_rsD)));
        haz_rt  = (hz.rtD != 5'd0) &&
                  (((hz.rtD == hz.a3E) && (hz.tnewE > hz.tuse_rtD)) ||
                   ((hz.rtD == hz.a3M) && (hz.tnewM > hz.tuse_rtD)));
        md_busy = hz.md_startE || (md_cnt != '0);
        stall   = haz_rs || haz_rt || (hz.md_useD && md_busy);
    end

    // Pipeline control with priority reset > exception > stall > idle.
    always_comb begin
        hz.stall_pc = 1'b0;
        hz.en_fd    = 1'b1;
        hz.clr_fd   = 1'b0;
        hz.clr_de   = 1'b0;
        hz.clr_em   = 1'b0;
        hz.clr_mw   = 1'b0;
        if (reset) begin
            hz.clr_fd = 1'b1;
            hz.clr_de = 1'b1;
            hz.clr_em = 1'b1;
            hz.clr_mw = 1'b1;
        end else if (hz.excM) begin
            hz.clr_fd = 1'b1;
            hz.clr_de = 1'b1;
            hz.clr_em = 1'b1;
        end else if (stall) begin
            hz.stall_pc = 1'b1;
            hz.en_fd    = 1'b0;
            hz.clr_de   = 1'b1;
        end
    end

    // Saturating count of cycles actually spent stalled (exceptions excluded).
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !hz.excM && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.md_busy      = md_busy;
    assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, busy cycles for div/divu; SHALL be 1..15.
REQ-003 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 rsD, rtD  in  5 each  D-stage source register numbers.
REQ-006 tuse_rsD, tuse_rtD  in  2 each  cycles until operand is needed; 3 = operand unused.
REQ-007 a3E, a3M  in  5 each  destination register in E and M; 0 = no write.
REQ-008 tnewE, tnewM  in  2 each  cycles until the result is available from E and M.
REQ-009 md_useD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 md_startE  in  1  mult or div issues in E this cycle.
REQ-011 md_divE  in  1  qualifies md_startE: 1 = div, 0 = mult.
REQ-012 excM  in  1  exception or eret committing in M this cycle.
REQ-013 stall_pc  out  1  hold the PC.
REQ-014 en_fd  out  1  F/D register enable.
REQ-015 clr_fd, clr_de, clr_em, clr_mw  out  1 each  synchronous clear for each pipeline register.
REQ-016 md_busy  out  1  multiply/divide unit is busy.
REQ-017 stall_cycles  out  32  count of stall cycles since reset.

Function
REQ-018 Register hazard: stall when rsD!=0, rsD==a3E and tnewE>tuse_rsD, or rsD!=0, rsD==a3M and tnewM>tuse_rsD; the same rules apply to rtD with tuse_rtD.
REQ-019 tuse==3 SHALL never cause a stall.
REQ-020 md_cnt is a 4-bit down-counter: load MULT_CYC on md_startE&!md_divE, or load DIV_CYC on md_startE&md_divE; otherwise decrement while nonzero.
REQ-021 md_busy = md_startE | (md_cnt!=0), combinational.
REQ-022 MD hazard: stall when md_useD & md_busy.
REQ-023 stall = register hazard | MD hazard; when stall=1 and excM=0: stall_pc=1, en_fd=0, clr_de=1, clr_fd=clr_em=clr_mw=0.
REQ-024 excM=1 has priority over stall: clr_fd=clr_de=clr_em=1, clr_mw=0, stall_pc=0, en_fd=1; the M instruction retires and younger instructions are killed.
REQ-025 excM SHALL NOT abort md_cnt; an in-flight HI/LO operation completes.
REQ-026 md_startE while md_cnt!=0 SHALL reload the counter; the D-side MD stall makes this unreachable under legal use.
REQ-027 Idle (no stall, no excM): stall_pc=0, en_fd=1, all clr_*=0.
REQ-028 stall_cycles increments by 1 on each clock edge where stall=1 and excM=0; it saturates at 0xFFFFFFFF.
REQ-029 Hazard outputs are combinational from inputs and md_cnt; md_cnt and stall_cycles are registered, with zero-cycle latency to stall decision.

Reset
REQ-030 While reset=1: clr_fd=clr_de=clr_em=clr_mw=1, stall_pc=0, en_fd=1.
REQ-031 Next edge with reset=1: md_cnt=0 and stall_cycles=0, so md_busy=0 after reset unless md_startE=1.
REQ-032 A reset during a div aborts it: md_cnt=0 after the edge.

Structure
REQ-033 A shared package holds the TUSE_NONE=3 constant, the MULT_CYC/DIV_CYC defaults and the 2-bit Tuse/Tnew typedef.
REQ-034 Sub-module md_busy_cnt (load/decrement counter) SHALL be instantiated; hazard compare logic stays inline.

Verification
REQ-035 Load-use: rsD=5, tuse_rsD=0, a3E=5, tnewE=2 -> stall_pc=1, en_fd=0, clr_de=1, stall_cycles+1.
REQ-036 Zero register: rsD=0, a3E=0, tnewE=2, tuse=0 -> no stall; and tuse_rsD=3 with a matching a3E -> no stall.
REQ-037 Div: md_startE=1, md_divE=1, then md_useD=1 -> md_busy high for 11 cycles (issue cycle plus 10), stall for the same span; with MULT the span is 6 cycles.
REQ-038 Exception with concurrent stall: excM=1 and load-use hazard -> clr_fd=clr_de=clr_em=1, clr_mw=0, stall_pc=0, stall_cycles unchanged.
REQ-039 Exception during div with md_cnt=7 -> md_cnt continues 6,5,...,0.
REQ-040 Reset mid-div with md_cnt=4 -> after the edge md_busy=0, stall_cycles=0; while reset=1 all clr_* are 1.
